keypad_hex_entry: RTL and testbench

Scans a 4x4 matrix hex keypad and debounces it, acting as the input-side counterpart of the multiplexed seven-segment display driver. Each accepted key press is shifted as one hex digit into a 32-bit entry register. That register connects directly to the display driver's 32-bit display-data input, so typed digits scroll in from the right. The block sits in the board I/O layer next to the display driver and shares its clock.

---
 rtl/keypad_hex_entry.sv | 237 +++++++++++++++++++++++
 tb/tb_keypad_hex_entry.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/keypad_hex_entry.sv
// 4x4 hex keypad scanner with frame-based debounce; accepted keys are shifted
// into a 32-bit entry register that feeds the seven-segment display driver.
module keypad_hex_entry #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [3:0]  row_o,
  input  logic [3:0]  col_i,
  input  logic        clr_i,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        key_held,
  output logic [31:0] entry_data
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    case ({row, col})
      4'h0: return 4'h1;
      4'h1: return 4'h2;
      4'h2: return 4'h3;
      4'h3: return 4'hA;
      4'h4: return 4'h4;
      4'h5: return 4'h5;
      4'h6: return 4'h6;
      4'h7: return 4'hB;
      4'h8: return 4'h7;
      4'h9: return 4'h8;
      4'hA: return 4'h9;
      4'hB: return 4'hC;
      4'hC: return 4'hE;
      4'hD: return 4'h0;
      4'hE: return 4'hF;
      4'hF: return 4'hD;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [1:0] onehot_index(input logic [3:0] v);
    case (v)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  logic [3:0]       col_meta_r, col_sync_r;
  logic [DIV_W-1:0] div_r;
  logic [1:0]       row_r;
  logic [3:0]       row_out_r;
  logic [1:0]       hits_r;
  logic [3:0]       hit_code_r;
  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [3:0]       cand_r, cand_s;
  logic             accept_s;
  logic             key_valid_r, key_held_r;
  logic [3:0]       key_code_r;
  logic [31:0]      entry_r;

  logic             sample_s, frame_end_s, frame_single_s, frame_none_s;
  logic [3:0]       row_low_s, code_s;
  logic [2:0]       total_s;
  logic [1:0]       hits_next_s;

  assign sample_s    = (div_r == DIV_LAST);
  assign frame_end_s = sample_s && (row_r == 2'd3);

  // Tally low columns seen so far this frame; hits saturate at 2 (= MULTI).
  always_comb begin
    row_low_s      = ~col_sync_r;
    total_s        = {1'b0, hits_r} + 3'($countones(row_low_s));
    hits_next_s    = (total_s >= 3'd2) ? 2'd2 : total_s[1:0];
    code_s         = (hits_r == 2'd1) ? hit_code_r : key_map(row_r, onehot_index(row_low_s));
    frame_single_s = frame_end_s && (total_s == 3'd1);
    frame_none_s   = (total_s == 3'd0);
  end

  // Two-flop synchronizer for the asynchronous column inputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_meta_r <= 4'b1111;
      col_sync_r <= 4'b1111;
    end else begin
      col_meta_r <= col_i;
      col_sync_r <= col_meta_r;
    end
  end

  // Row scan timing and registered row drive.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_r     <= '0;
      row_r     <= 2'd0;
      row_out_r <= 4'b1110;
    end else if (sample_s) begin
      div_r     <= '0;
      row_r     <= row_r + 2'd1;
      row_out_r <= ~(4'b0001 << (row_r + 2'd1));
    end else begin
      div_r     <= div_r + DIV_W'(1);
    end
  end

  // Per-frame hit accumulator, cleared as each frame completes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hits_r     <= 2'd0;
      hit_code_r <= 4'h0;
    end else if (frame_end_s) begin
      hits_r     <= 2'd0;
      hit_code_r <= 4'h0;
    end else if (sample_s) begin
      hits_r     <= hits_next_s;
      hit_code_r <= code_s;
    end else begin
      hits_r     <= hits_r;
      hit_code_r <= hit_code_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      cand_r  <= 4'h0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      cand_r  <= cand_s;
    end
  end

  // Debounce FSM; MULTI frames never match and so break any run.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    cand_s   = cand_r;
    accept_s = 1'b0;
    if (frame_end_s) begin
      case (state_r)
        IDLE: begin
          if (frame_single_s) begin
            cand_s  = code_s;
            cnt_s   = CNT_W'(1);
            state_s = DEBOUNCE;
          end else begin
            state_s = IDLE;
          end
        end
        DEBOUNCE: begin
          if (frame_single_s && (code_s == cand_r)) begin
            cnt_s = cnt_r + CNT_W'(1);
            if ((cnt_r + CNT_W'(1)) == CNT_LAST) begin
              state_s  = PRESSED;
              accept_s = 1'b1;
            end else begin
              state_s = DEBOUNCE;
            end
          end else begin
            cnt_s   = '0;
            state_s = IDLE;
          end
        end
        PRESSED: begin
          if (frame_none_s) begin
            cnt_s   = CNT_W'(1);
            state_s = RELEASE;
          end else begin
            state_s = PRESSED;
          end
        end
        RELEASE: begin
          if (frame_none_s) begin
            cnt_s = cnt_r + CNT_W'(1);
            if ((cnt_r + CNT_W'(1)) == CNT_LAST) begin
              cnt_s   = '0;
              state_s = IDLE;
            end else begin
              state_s = RELEASE;
            end
          end else begin
            state_s = PRESSED;
          end
        end
        default: begin
          cnt_s   = '0;
          state_s = IDLE;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Registered outputs; clear wins over shift but still keeps the new digit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      key_valid_r <= 1'b0;
      key_code_r  <= 4'h0;
      key_held_r  <= 1'b0;
      entry_r     <= 32'h0;
    end else begin
      key_valid_r <= accept_s;
      key_held_r  <= (state_s == PRESSED) || (state_s == RELEASE);
      if (accept_s) begin
        key_code_r <= cand_r;
      end else begin
        key_code_r <= key_code_r;
      end
      if (clr_i) begin
        entry_r <= accept_s ? {28'h0, cand_r} : 32'h0;
      end else if (accept_s) begin
        entry_r <= {entry_r[27:0], cand_r};
      end else begin
        entry_r <= entry_r;
      end
    end
  end

  assign row_o      = row_out_r;
  assign key_valid  = key_valid_r;
  assign key_code   = key_code_r;
  assign key_held   = key_held_r;
  assign entry_data = entry_r;

endmodule

// File: tb/tb_keypad_hex_entry.sv
// Frame-level randomized bench for keypad_hex_entry with a behavioural
// keypad/debounce reference model.
module tb_keypad_hex_entry;
  localparam int SD    = 4;
  localparam int DB    = 3;
  localparam int FRAME = 4 * SD;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        clr_i = 1'b0;
  logic [3:0]  row_o, col_i, key_code;
  logic        key_valid, key_held;
  logic [31:0] entry_data;
  logic [15:0] pressed = 16'h0;

  int checks = 0;
  int errors = 0;

  logic [3:0] code_tab [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

  bit          m_held, m_valid;
  int          m_streak, m_rel;
  logic [3:0]  m_cand, m_code;
  logic [31:0] m_entry;

  keypad_hex_entry #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
    .clk(clk), .rstn(rstn), .row_o(row_o), .col_i(col_i), .clr_i(clr_i),
    .key_valid(key_valid), .key_code(key_code), .key_held(key_held),
    .entry_data(entry_data)
  );

  always #5 clk = ~clk;

  // Ideal switch matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col_i = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !row_o[r]) col_i[c] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] kb(input int r, input int c);
    logic [15:0] one = 16'h1;
    return one << (r*4 + c);
  endfunction

  task automatic model_reset();
    m_held = 0; m_valid = 0; m_streak = 0; m_rel = 0;
    m_cand = 4'h0; m_code = 4'h0; m_entry = 32'h0;
  endtask

  task automatic model_frame(input logic [15:0] m, input bit clr);
    int n;
    logic [3:0] k;
    n = $countones(m);
    k = 4'h0;
    for (int i = 0; i < 16; i++) if (m[i]) k = code_tab[i];
    m_valid = 0;
    if (!m_held) begin
      if (n == 1 && m_streak > 0 && k == m_cand) m_streak++;
      else if (n == 1 && m_streak == 0) begin m_streak = 1; m_cand = k; end
      else m_streak = 0;
      if (m_streak == DB) begin
        m_valid = 1; m_held = 1; m_rel = 0; m_streak = 0; m_code = m_cand;
      end
    end else begin
      m_rel = (n == 0) ? m_rel + 1 : 0;
      if (m_rel == DB) m_held = 0;
    end
    if (clr) m_entry = m_valid ? {28'h0, m_cand} : 32'h0;
    else if (m_valid) m_entry = {m_entry[27:0], m_cand};
  endtask

  // Called at the negedge of the first cycle of a frame.
  task automatic run_frame(input logic [15:0] m, input bit clr);
    int extra;
    logic [3:0] er;
    extra = 0;
    check("key_valid", key_valid, m_valid);
    check("key_code", key_code, m_code);
    check("key_held", key_held, m_held);
    check("entry_data", entry_data, m_entry);
    pressed = m;
    for (int i = 0; i < FRAME; i++) begin
      if (i % SD == 0) begin
        er = ~(4'b0001 << (i / SD));
        check("row_o", row_o, er);
      end
      if (i > 0 && key_valid) extra++;
      if (i == FRAME - 1) clr_i = clr;
      @(negedge clk);
    end
    clr_i = 1'b0;
    check("single_pulse", extra, 0);
    model_frame(m, clr);
  endtask

  task automatic press(input logic [15:0] m, input int on, input int off);
    for (int i = 0; i < on; i++) run_frame(m, 1'b0);
    for (int i = 0; i < off; i++) run_frame(16'h0, 1'b0);
  endtask

  initial begin
    logic [15:0] seq [9];
    logic [15:0] m;
    int kind, hold;
    seq = '{kb(0,0), kb(0,1), kb(0,2), kb(0,3), kb(1,3), kb(2,3), kb(3,3), kb(3,0), kb(2,2)};
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_row_o", row_o, 4'b1110);
    check("rst_key_valid", key_valid, 1'b0);
    check("rst_entry", entry_data, 32'h0);
    rstn = 1'b1;

    // Key 6: accepted after three frames, held until three empty frames.
    press(kb(1,2), 3, 0);
    check("k6_valid", key_valid, 1'b1);
    check("k6_code", key_code, 4'h6);
    check("k6_entry", entry_data, 32'h00000006);
    press(kb(1,2), 2, 4);

    // Eight-digit scroll then wrap.
    for (int i = 0; i < 8; i++) press(seq[i], 4, 4);
    check("seq8_entry", entry_data, 32'h123ABCDE);
    press(seq[8], 4, 4);
    check("seq9_entry", entry_data, 32'h23ABCDE9);

    // Bounce shorter than the debounce count.
    for (int i = 0; i < 5; i++) press(kb(1,1), 2, 2);
    check("bounce_entry", entry_data, 32'h23ABCDE9);

    // Two keys together, then one released.
    press(kb(0,0) | kb(0,1), 10, 0);
    check("multi_held", key_held, 1'b0);
    press(kb(0,0), 3, 0);
    check("multi_then_1", key_code, 4'h1);
    press(kb(0,0), 1, 4);

    // Long hold of F with clear on the accept frame, then a lone clear.
    run_frame(kb(3,2), 1'b0);
    run_frame(kb(3,2), 1'b0);
    run_frame(kb(3,2), 1'b1);
    check("clr_on_accept", entry_data, 32'h0000000F);
    press(kb(3,2), 17, 4);
    run_frame(16'h0, 1'b1);
    check("clr_alone", entry_data, 32'h0);
    check("clr_keeps_code", key_code, 4'hF);

    // Reset during debounce with key 7 still held.
    press(kb(1,0), 3, 4);
    press(kb(2,0), 2, 0);
    rstn = 1'b0;
    #1;
    check("mid_rst_row_o", row_o, 4'b1110);
    check("mid_rst_valid", key_valid, 1'b0);
    check("mid_rst_code", key_code, 4'h0);
    check("mid_rst_held", key_held, 1'b0);
    check("mid_rst_entry", entry_data, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    press(kb(2,0), 3, 0);
    check("after_rst_code", key_code, 4'h7);
    press(kb(2,0), 1, 4);

    // Random press patterns and clears.
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 3);
      hold = $urandom_range(1, 5);
      m = 16'h0;
      if (kind == 1 || kind == 2) m = kb($urandom_range(0, 3), $urandom_range(0, 3));
      else if (kind == 3) m = kb($urandom_range(0, 3), $urandom_range(0, 3)) |
                              kb($urandom_range(0, 3), $urandom_range(0, 3));
      for (int f = 0; f < hold; f++) run_frame(m, ($urandom_range(0, 7) == 0));
    end
    press(16'h0, 0, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
